// File: rtl/rv32i_types.sv
// Shared sizes and types for the cache-to-burst-memory arbiter.
package rv32i_types;

    localparam int unsigned ADDR_BITS     = 32;
    localparam int unsigned LINE_BITS     = 256;
    localparam int unsigned BEAT_BITS     = 64;
    localparam int unsigned BEATS         = 4;
    localparam int unsigned BEAT_IDX_BITS = $clog2(BEATS);
    localparam int unsigned LINE_BYTES    = LINE_BITS / 8;

    // Clears the byte-in-line offset so bursts always start on a line boundary.
    localparam logic [ADDR_BITS-1:0] LINE_ADDR_MASK = ~ADDR_BITS'(LINE_BYTES - 1);

    localparam logic [BEAT_IDX_BITS-1:0] LAST_BEAT = BEAT_IDX_BITS'(BEATS - 1);

    typedef logic [BEATS-1:0][BEAT_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one burst memory between icache and dcache, one line transaction at a
// time, with round-robin tie-break between the two caches.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_read,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic [ADDR_BITS-1:0] bmem_address,
    output logic                 bmem_read,
    output logic                 bmem_write,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_resp
);

    arb_state_t               state_q, state_d;
    logic [BEAT_IDX_BITS-1:0] beat_q, beat_d;
    line_t                    line_q, line_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [BEAT_BITS-1:0]     wdata_q, wdata_d;
    logic                     gnt_dcache_q, gnt_dcache_d;
    logic                     last_dcache_q, last_dcache_d;
    logic                     bmem_read_q, bmem_read_d;
    logic                     bmem_write_q, bmem_write_d;
    logic                     i_resp_q, i_resp_d;
    logic                     d_resp_q, d_resp_d;

    logic                     d_req_c;
    logic                     pick_dcache_c;
    logic [BEAT_IDX_BITS-1:0] beat_nx_c;

    // A tie goes to whichever cache was not served last.
    assign d_req_c       = d_read | d_write;
    assign pick_dcache_c = d_req_c & (~i_read | ~last_dcache_q);
    assign beat_nx_c     = beat_q + BEAT_IDX_BITS'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        line_d        = line_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        gnt_dcache_d  = gnt_dcache_q;
        last_dcache_d = last_dcache_q;
        bmem_read_d   = bmem_read_q;
        bmem_write_d  = bmem_write_q;
        i_resp_d      = 1'b0;
        d_resp_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_read | d_req_c) begin
                    gnt_dcache_d  = pick_dcache_c;
                    last_dcache_d = pick_dcache_c;
                    beat_d        = '0;
                    addr_d        = (pick_dcache_c ? d_addr : i_addr) & LINE_ADDR_MASK;
                    // A simultaneous read and write from the dcache is a writeback.
                    if (pick_dcache_c && d_write) begin
                        line_d       = d_wdata;
                        wdata_d      = d_wdata[BEAT_BITS-1:0];
                        bmem_write_d = 1'b1;
                        state_d      = WR_BURST;
                    end else begin
                        bmem_read_d  = 1'b1;
                        state_d      = RD_BURST;
                    end
                end
            end

            RD_BURST: begin
                if (bmem_resp) begin
                    line_d[beat_q] = bmem_rdata;
                    beat_d         = beat_nx_c;
                    if (beat_q == LAST_BEAT) begin
                        bmem_read_d = 1'b0;
                        i_resp_d    = ~gnt_dcache_q;
                        d_resp_d    = gnt_dcache_q;
                        state_d     = DONE;
                    end
                end
            end

            WR_BURST: begin
                if (bmem_resp) begin
                    beat_d  = beat_nx_c;
                    wdata_d = line_q[beat_nx_c];
                    if (beat_q == LAST_BEAT) begin
                        bmem_write_d = 1'b0;
                        i_resp_d     = ~gnt_dcache_q;
                        d_resp_d     = gnt_dcache_q;
                        state_d      = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            line_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            gnt_dcache_q  <= 1'b0;
            last_dcache_q <= 1'b1;
            bmem_read_q   <= 1'b0;
            bmem_write_q  <= 1'b0;
            i_resp_q      <= 1'b0;
            d_resp_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            line_q        <= line_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            gnt_dcache_q  <= gnt_dcache_d;
            last_dcache_q <= last_dcache_d;
            bmem_read_q   <= bmem_read_d;
            bmem_write_q  <= bmem_write_d;
            i_resp_q      <= i_resp_d;
            d_resp_q      <= d_resp_d;
        end
    end

    // Both caches see the line buffer continuously; resp qualifies it.
    assign i_rdata      = line_q;
    assign d_rdata      = line_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;
    assign bmem_address = addr_q;
    assign bmem_read    = bmem_read_q;
    assign bmem_write   = bmem_write_q;
    assign bmem_wdata   = wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
- REQ-002 The block SHALL have no parameters; all sizes SHALL come from the shared package.
- REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
  - i_addr  in  32  icache line-miss address.
  - i_read  in  1  icache line-read request.
  - i_rdata  out  256  line returned to icache.
  - i_resp  out  1  icache request complete.
  - d_addr  in  32  dcache line address.
  - d_read  in  1  dcache line-read request.
  - d_write  in  1  dcache line-writeback request.
  - d_wdata  in  256  writeback line.
  - d_rdata  out  256  line returned to dcache.
  - d_resp  out  1  dcache request complete.
  - bmem_address  out  32  line-aligned burst address.
  - bmem_read  out  1  burst read active.
  - bmem_write  out  1  burst write active.
  - bmem_rdata  in  64  read beat.
  - bmem_wdata  out  64  write beat.
  - bmem_resp  in  1  beat accepted or valid.

Function
- REQ-004 The block SHALL share the single burst memory between the icache and dcache, one line transaction at a time.
- REQ-005 The FSM SHALL have four states: IDLE, RD_BURST, WR_BURST and DONE.
- REQ-006 Grant in IDLE:
  - The block SHALL evaluate requests every cycle in IDLE.
  - A grant SHALL move the FSM to RD_BURST (icache read, dcache read) or WR_BURST (dcache write) on the next edge.
- REQ-007 At grant, the block SHALL capture the requester id, {addr[31:5],5'b0} and, for writes, d_wdata into internal registers; later requester input changes SHALL NOT affect the burst.
- REQ-008 Tie-break: when both caches request in the same IDLE cycle, the grant SHALL go to the cache not granted last (round-robin via a last_grant flop).
- REQ-009 If d_read and d_write are both high, the block SHALL treat the request as a write.
- REQ-010 In RD_BURST:
  - bmem_read SHALL be 1 and bmem_address SHALL be the captured address.
  - Each cycle with bmem_resp=1 SHALL store bmem_rdata into line bits [64k+63:64k], k = the 2-bit beat counter, then increment k.
- REQ-011 In WR_BURST:
  - bmem_write SHALL be 1 and bmem_wdata SHALL be captured-line beat k.
  - Each bmem_resp=1 SHALL increment k.
- REQ-012 The beat on which k=3 and bmem_resp=1 SHALL:
  - deassert bmem_read/bmem_write from the next cycle;
  - move the FSM to DONE;
  - wrap k to 0.
- REQ-013 Cycles with bmem_resp=0 mid-burst SHALL hold state, k and the outputs.
- REQ-014 DONE SHALL last exactly one cycle:
  - The granted cache's resp SHALL be 1 with its rdata equal to the assembled line.
  - The other resp SHALL be 0.
  - The FSM SHALL return to IDLE.
- REQ-015 Latency: a request sampled in IDLE at cycle N SHALL yield bmem_read/bmem_write=1 at N+1; the last beat at cycle M SHALL yield resp=1 at M+1; a new grant SHALL be possible at M+2.
- REQ-016 i_rdata and d_rdata SHALL both equal the internal line buffer at all times; only the resp strobes qualify them.
- REQ-017 bmem_read and bmem_write SHALL never be 1 in the same cycle, and no cache SHALL see resp while the FSM is not in DONE.
- REQ-018 A requester dropping its request mid-burst SHALL NOT abort the burst; the resp SHALL still pulse and be ignored.

Reset
- REQ-019 With rst=1 at an edge, the block SHALL set state=IDLE, k=0 and last_grant=dcache (so the icache wins the first tie), and SHALL clear the captured address and line buffer to 0.
- REQ-020 During reset, all outputs SHALL be 0 from the following cycle.
- REQ-021 Reset mid-burst SHALL abandon the burst without a resp pulse.

Structure
- REQ-022 The shared package rv32i_types SHALL hold LINE_BITS=256, BEAT_BITS=64, BEATS=4 and enum arb_state_t {IDLE, RD_BURST, WR_BURST, DONE}.
- REQ-023 The block SHALL be a single module with one FSM, a beat counter and a line buffer; no sub-module is required.

Verification
- REQ-024 Icache read:
  - Stimulus: i_read, i_addr=0x6000_0014; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  - Required: bmem_address=0x6000_0000; i_resp one cycle with i_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; d_resp=0 throughout.
- REQ-025 Dcache writeback:
  - Stimulus: d_write, d_addr=0x6000_0120, d_wdata=256'h0123...; bmem_resp=1 every other cycle.
  - Required: bmem_wdata steps through beats 0..3, each held until its bmem_resp; d_resp pulses once after the fourth accepted beat.
- REQ-026 Simultaneous requests after reset:
  - Stimulus: i_read and d_read both high after reset.
  - Required: icache granted first, dcache second; a further tie goes to the icache.
- REQ-027 Read/write conflict:
  - Stimulus: d_read=d_write=1.
  - Required: WR_BURST entered; bmem_read never 1.
- REQ-028 Reset mid-burst:
  - Stimulus: rst asserted after beat 2 of a read.
  - Required: bmem_read=0 next cycle, no resp; a subsequent request restarts at k=0 with the full 4 beats.
